mux_tree_pipe: RTL
==================

Name: mux_tree_pipe

Overview:
- Parametrised, pipelined N:1 multiplexer: a log2(NUM_IN)-level tree of 2:1 selections with a register after every level.
- Successor to the fixed combinational 4:1 mux, generalised in channel count and data width.
- Adds a valid/ready handshake with backpressure so it can sit between streaming stages on wide datapaths without limiting timing.

Parameters:
NUM_IN, 8, number of input channels; power of two, >= 2
WIDTH, 8, bits per channel
(derived, not overridable) SEL_W = log2(NUM_IN) = number of tree levels = pipeline depth

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  NUM_IN*WIDTH  flattened channels; channel i occupies bits [i*WIDTH +: WIDTH]
in_sel  input  SEL_W  channel select, sampled with in_data
in_valid  input  1  upstream offers in_data/in_sel
in_ready  output  1  block accepts this cycle
out_data  output  WIDTH  selected channel
out_sel  output  SEL_W  in_sel that produced out_data
out_valid  output  1  out_data/out_sel valid
out_ready  input  1  downstream accepts this cycle

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits, data registers and carried-select registers clear to 0. out_valid=0, out_data=0, out_sel=0. in_ready=1 combinationally while out_valid=0.
- Release: first accept possible on the first rising edge after rst_n goes high.
- Tree structure:
  - Level k (k=0..SEL_W-1) selects between element pairs (2j, 2j+1) of the previous level using carried select bit k (LSB first).
  - Level 0 reads in_data directly.
  - Each level's result is registered together with its valid bit and the full original select.
- Advance enable: adv = !out_valid || out_ready. All stages shift together when adv=1 and hold when adv=0 (global stall).
  - in_ready = adv, combinational.
  - No dependence of in_ready on in_valid.
- Transfer rules:
  - Input transfer on an edge with in_valid && in_ready.
  - Output transfer on an edge with out_valid && out_ready.
  - When adv=1 and in_valid=0, a bubble (valid=0) enters stage 0. Bubbles are not collapsed.
- Latency: a beat accepted at edge T appears at the output (out_valid=1) after edge T+SEL_W-1, i.e. SEL_W register stages, provided adv stays high.
  - Throughput: 1 beat/cycle.
- Stall:
  - While out_valid=1 and out_ready=0, out_data, out_sel and out_valid hold stable and every internal stage holds.
  - No beat is lost or duplicated.
- Simultaneous accept and drain on the same edge (pipeline full, out_ready=1, in_valid=1): both happen; the pipeline stays full.
- Data registers may load when their incoming valid=0. The value of out_data when out_valid=0 is don't-care after reset.
- in_sel is full-range for a power-of-two NUM_IN; no out-of-range case exists.
- Reset mid-stream: all in-flight beats are discarded immediately. There is no output transfer on or after the asserting edge until new data is accepted.
- NUM_IN=2: single stage, latency 1.

Test Plan:
1. NUM_IN=8, WIDTH=8, channel i = 0x10+i, out_ready=1. Stream in_sel = 0..7 on 8 consecutive cycles -> after 3-cycle latency, out_data = 0x10..0x17 on consecutive cycles with out_sel = 0..7 and out_valid continuously 1.
2. Backpressure: send in_sel=5 and in_sel=2 back-to-back, hold out_ready=0 -> out_valid rises with out_data=0x15, which holds stable. in_ready goes 0 once out_valid=1. Release out_ready -> 0x15 then 0x12, nothing lost or duplicated.
3. Bubbles: in_valid pattern 1,0,1 with sel 7,x,0 -> output valid pattern 1,0,1 with data 0x17, -, 0x10.
4. Reset mid-stream: 3 beats in flight, pulse rst_n low asynchronously between edges -> out_valid=0, out_data=0 immediately, and in_ready=1. After release, a new beat with sel=3 yields 0x13 after 3 cycles.
5. Parameter sweep NUM_IN=2 (WIDTH=16) and NUM_IN=16 (WIDTH=4) -> latency 1 and 4 respectively, correct channel for every sel value against a reference model, with random in_valid/out_ready.
6. Random handshake soak (10k cycles, random data/sel/valid/ready) -> scoreboard shows the output sequence equals the accepted-input sequence, with data and sel matching.

Source files
------------

// File: rtl/mux_tree_pipe.sv
// Pipelined NUM_IN:1 multiplexer built as a registered tree of 2:1 selections.
// The whole pipeline stalls together when the output beat is held by the consumer.
module mux_tree_pipe #(
  parameter int NUM_IN = 8,
  parameter int WIDTH  = 8,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int NODES = NUM_IN - 1;

  // All tree nodes in one array: level k outputs start at node_base(k).
  logic [WIDTH-1:0] node_q [NODES];
  logic             vld_q  [SEL_W];
  logic [SEL_W-1:0] sel_q  [SEL_W];
  logic             adv;

  function automatic int node_base(input int k);
    return NUM_IN - (NUM_IN >> k);
  endfunction

  assign out_valid = vld_q[SEL_W-1];
  assign out_sel   = sel_q[SEL_W-1];
  assign out_data  = node_q[NODES-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NODES; n++) node_q[n] <= '0;
      for (int k = 0; k < SEL_W; k++) begin
        vld_q[k] <= 1'b0;
        sel_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q[0] <= in_valid;
      sel_q[0] <= in_sel;
      for (int j = 0; j < NUM_IN / 2; j++)
        node_q[j] <= in_sel[0] ? in_data[(2*j+1)*WIDTH +: WIDTH]
                               : in_data[(2*j)*WIDTH +: WIDTH];
      // Deeper levels steer with the select bit carried alongside the beat.
      for (int k = 1; k < SEL_W; k++) begin
        vld_q[k] <= vld_q[k-1];
        sel_q[k] <= sel_q[k-1];
        for (int j = 0; j < (NUM_IN >> (k + 1)); j++)
          node_q[node_base(k) + j] <= sel_q[k-1][k]
                                      ? node_q[node_base(k-1) + 2*j + 1]
                                      : node_q[node_base(k-1) + 2*j];
      end
    end
  end

endmodule
